// File: rtl/apb_master_fsm_if.sv
// Request/response and APB bus bundle for apb_master_fsm.
// master: the bridge's view; slave: the requester/APB-completer side that drives it.
interface apb_master_fsm_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        Pwrite;
  logic        Penable;
  logic [2:0]  Pselx;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;
  logic [31:0] Prdata;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        err;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, Prdata,
    output req_ready, Pwrite, Penable, Pselx, Paddr, Pwdata, rd_data, rd_valid, err
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, Prdata,
    input  req_ready, Pwrite, Penable, Pselx, Paddr, Pwdata, rd_data, rd_valid, err
  );
endinterface

// File: rtl/apb_master_fsm.sv
// Request-to-APB bridge: three-slave fixed decode, SETUP/ACCESS sequencing with
// back-to-back issue from ACCESS, read-data capture and a one-cycle decode-miss pulse.
module apb_master_fsm (
  input logic              Hclk,
  input logic              Hresetn,
  apb_master_fsm_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [2:0]  psel, psel_nxt;
  logic        penable, penable_nxt;
  logic        pwrite, pwrite_nxt;
  logic [31:0] paddr, paddr_nxt;
  logic [31:0] pwdata, pwdata_nxt;
  logic [31:0] rd_data, rd_data_nxt;
  logic        rd_valid, rd_valid_nxt;
  logic        err, err_nxt;

  logic        ready;
  logic        accept;
  logic [2:0]  sel_dec;

  function automatic logic [2:0] decode(input logic [5:0] region);
    case (region)
      6'b100000: decode = 3'b001;
      6'b100001: decode = 3'b010;
      6'b100010: decode = 3'b100;
      default:   decode = 3'b000;
    endcase
  endfunction

  assign ready   = (state != SETUP);
  assign accept  = bus.req_valid & ready;
  assign sel_dec = decode(bus.req_addr[31:26]);

  always_comb begin
    state_nxt    = state;
    psel_nxt     = psel;
    penable_nxt  = 1'b0;
    pwrite_nxt   = pwrite;
    paddr_nxt    = paddr;
    pwdata_nxt   = pwdata;
    rd_data_nxt  = rd_data;
    rd_valid_nxt = 1'b0;
    err_nxt      = 1'b0;

    case (state)
      SETUP: begin
        state_nxt   = ACCESS;
        penable_nxt = 1'b1;
      end
      IDLE, ACCESS: begin
        // A read completes on the same edge that may accept the next request.
        if (state == ACCESS && !pwrite) begin
          rd_data_nxt  = bus.Prdata;
          rd_valid_nxt = 1'b1;
        end
        state_nxt = IDLE;
        psel_nxt  = 3'b000;
        if (accept) begin
          if (sel_dec != 3'b000) begin
            state_nxt  = SETUP;
            psel_nxt   = sel_dec;
            pwrite_nxt = bus.req_write;
            paddr_nxt  = bus.req_addr;
            pwdata_nxt = bus.req_wdata;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        psel_nxt  = 3'b000;
      end
    endcase
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state    <= IDLE;
      psel     <= 3'b000;
      penable  <= 1'b0;
      pwrite   <= 1'b0;
      paddr    <= 32'd0;
      pwdata   <= 32'd0;
      rd_data  <= 32'd0;
      rd_valid <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      psel     <= psel_nxt;
      penable  <= penable_nxt;
      pwrite   <= pwrite_nxt;
      paddr    <= paddr_nxt;
      pwdata   <= pwdata_nxt;
      rd_data  <= rd_data_nxt;
      rd_valid <= rd_valid_nxt;
      err      <= err_nxt;
    end
  end

  assign bus.req_ready = ready;
  assign bus.Pselx     = psel;
  assign bus.Penable   = penable;
  assign bus.Pwrite    = pwrite;
  assign bus.Paddr     = paddr;
  assign bus.Pwdata    = pwdata;
  assign bus.rd_data   = rd_data;
  assign bus.rd_valid  = rd_valid;
  assign bus.err       = err;

endmodule

// File: tb/tb_apb_master_fsm.sv
// Bench for apb_master_fsm: directed bus scenarios followed by random traffic,
// checked against a per-cycle expectation timeline built from accepted requests.
module tb_apb_master_fsm;

  localparam int NC = 4096;

  logic Hclk;
  logic Hresetn;
  apb_master_fsm_if bus ();

  apb_master_fsm dut (
    .Hclk    (Hclk),
    .Hresetn (Hresetn),
    .bus     (bus.master)
  );

  initial Hclk = 1'b0;
  always #5 Hclk = ~Hclk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Expectation timeline, indexed by the cycle that follows edge number cyc.
  logic [2:0]  e_sel    [NC];
  logic        e_pen    [NC];
  logic        e_setup  [NC];
  logic        e_acc_rd [NC];
  logic        e_rdv    [NC];
  logic        e_err    [NC];
  // Values the bus holds between transfers.
  logic [31:0] h_addr, h_wd, h_rd;
  logic        h_wr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=0x%08h want=0x%08h", tag, cyc, obs, exp);
    end
  endtask

  task automatic clear_from(input int c);
    for (int i = c; i < NC; i++) begin
      e_sel[i] = 3'b000; e_pen[i] = 1'b0; e_setup[i] = 1'b0;
      e_acc_rd[i] = 1'b0; e_rdv[i] = 1'b0; e_err[i] = 1'b0;
    end
  endtask

  task automatic check_cycle();
    chk("req_ready", {31'd0, bus.req_ready}, {31'd0, !e_setup[cyc]});
    chk("Pselx",     {29'd0, bus.Pselx},     {29'd0, e_sel[cyc]});
    chk("Penable",   {31'd0, bus.Penable},   {31'd0, e_pen[cyc]});
    chk("Pwrite",    {31'd0, bus.Pwrite},    {31'd0, h_wr});
    chk("Paddr",     bus.Paddr,              h_addr);
    chk("Pwdata",    bus.Pwdata,             h_wd);
    chk("rd_valid",  {31'd0, bus.rd_valid},  {31'd0, e_rdv[cyc]});
    chk("rd_data",   bus.rd_data,            h_rd);
    chk("err",       {31'd0, bus.err},       {31'd0, e_err[cyc]});
  endtask

  // One clock: present inputs, update the model, advance, check on the falling edge.
  task automatic step(input logic v, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [31:0] prd, output logic acc);
    int region;
    bus.req_valid = v;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.Prdata    = prd;
    acc = 1'b0;
    if (e_acc_rd[cyc]) begin
      h_rd = prd;
      e_rdv[cyc + 1] = 1'b1;
    end
    if (v && !e_setup[cyc]) begin
      acc = 1'b1;
      region = int'(a[31:26]) - 32;
      if (region >= 0 && region <= 2) begin
        e_setup[cyc + 1]  = 1'b1;
        e_sel[cyc + 1]    = 3'(1 << region);
        e_sel[cyc + 2]    = 3'(1 << region);
        e_pen[cyc + 2]    = 1'b1;
        e_acc_rd[cyc + 2] = !w;
        h_addr = a; h_wd = d; h_wr = w;
      end else begin
        e_err[cyc + 1] = 1'b1;
      end
    end
    @(posedge Hclk);
    cyc++;
    @(negedge Hclk);
    check_cycle();
  endtask

  task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d);
    logic acc;
    int tries;
    tries = 0;
    acc = 1'b0;
    while (!acc && tries < 4) begin
      step(1'b1, w, a, d, $urandom, acc);
      tries++;
    end
    chk("accept_bound", {31'd0, acc}, 32'd1);
  endtask

  task automatic idle(input int n, input logic [31:0] prd);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0, 32'd0, prd, acc);
  endtask

  // Asynchronous reset pulse mid-cycle, released before the next rising edge.
  task automatic reset_pulse();
    #2 Hresetn = 1'b0;
    #1;
    chk("rst_Pselx",    {29'd0, bus.Pselx},    32'd0);
    chk("rst_Penable",  {31'd0, bus.Penable},  32'd0);
    chk("rst_Pwrite",   {31'd0, bus.Pwrite},   32'd0);
    chk("rst_Paddr",    bus.Paddr,             32'd0);
    chk("rst_Pwdata",   bus.Pwdata,            32'd0);
    chk("rst_rd_data",  bus.rd_data,           32'd0);
    chk("rst_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
    chk("rst_err",      {31'd0, bus.err},      32'd0);
    chk("rst_ready",    {31'd0, bus.req_ready}, 32'd1);
    #1 Hresetn = 1'b1;
    clear_from(cyc);
    h_addr = 32'd0; h_wd = 32'd0; h_rd = 32'd0; h_wr = 1'b0;
  endtask

  initial begin
    logic        pend, pw, acc;
    logic [31:0] pa, pd;

    clear_from(0);
    h_addr = 32'd0; h_wd = 32'd0; h_rd = 32'd0; h_wr = 1'b0;
    Hresetn = 1'b0;
    bus.req_valid = 1'b0; bus.req_write = 1'b0;
    bus.req_addr = 32'd0; bus.req_wdata = 32'd0; bus.Prdata = 32'd0;
    repeat (3) @(negedge Hclk);
    Hresetn = 1'b1;
    check_cycle();

    // Single write to slave 0.
    send(1'b1, 32'h8000_0010, 32'hDEAD_BEEF);
    idle(3, 32'h0);
    // Single read from slave 1 returning 30.
    send(1'b0, 32'h8400_0004, 32'h0);
    step(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, acc);
    step(1'b0, 1'b0, 32'd0, 32'd0, 32'd30, acc);
    idle(2, 32'h0);
    chk("read_value", bus.rd_data, 32'd30);
    // Back-to-back write then read with req_valid held; second waits out SETUP.
    send(1'b1, 32'h8800_0000, 32'h1234_5678);
    send(1'b0, 32'h8000_0008, 32'h0);
    step(1'b0, 1'b0, 32'd0, 32'd0, 32'hCAFE_F00D, acc);
    idle(2, 32'h0);
    // Decode miss, then a miss directly after a read's ACCESS.
    send(1'b1, 32'h1000_0000, 32'h5555_AAAA);
    idle(2, 32'h0);
    send(1'b0, 32'h8000_0100, 32'h0);
    send(1'b0, 32'hFC00_0000, 32'h0);
    idle(2, 32'h0);
    // Reset during ACCESS of a read, then a normal request right after release.
    send(1'b0, 32'h8400_0040, 32'h0);
    step(1'b0, 1'b0, 32'd0, 32'd0, 32'h7777_7777, acc);
    reset_pulse();
    send(1'b1, 32'h8800_0044, 32'hA5A5_5A5A);
    idle(3, 32'h0);

    // Randomized traffic; the requester holds a request until it is accepted.
    pend = 1'b0; pw = 1'b0; pa = 32'd0; pd = 32'd0;
    for (int i = 0; i < 2000; i++) begin
      if (!pend && $urandom_range(0, 3) != 0) begin
        pend = 1'b1;
        pw   = 1'($urandom_range(0, 1));
        pd   = $urandom;
        if ($urandom_range(0, 4) != 0)
          pa = {4'b1000, 2'($urandom_range(0, 2)), 26'($urandom)};
        else
          pa = $urandom;
      end
      step(pend, pw, pa, pd, $urandom, acc);
      if (acc) pend = 1'b0;
      if ($urandom_range(0, 199) == 0) reset_pulse();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
